mips_cpu_run_monitor: RTL and testbench

MIPS_CPU_RUN_MONITOR -- requirements
Module: mips_cpu_run_monitor

---
 rtl/mips_tb_pkg.sv | 23 ++
 rtl/mips_cpu_run_monitor_sat_counter.sv | 22 ++
 rtl/mips_cpu_run_monitor.sv | 113 +++++++++++
 tb/tb_mips_cpu_run_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_tb_pkg.sv
// Shared definitions for the CPU run monitor: FSM states, fail codes and
// counter widths.
package mips_tb_pkg;

   // Monitor FSM states; DONE and FAIL are terminal until reset.
   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      RUNNING    = 2'd1,
      DONE       = 2'd2,
      FAIL       = 2'd3
   } run_state_t;

   // Reason a run ended abnormally.
   typedef logic [1:0] fail_code_t;

   localparam fail_code_t FAIL_NONE    = 2'b00;
   localparam fail_code_t FAIL_NOSTART = 2'b01;
   localparam fail_code_t FAIL_TIMEOUT = 2'b10;

   localparam int unsigned CYCLE_W  = 32;
   localparam int unsigned STROBE_W = 16;

endpackage

// File: rtl/mips_cpu_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   // Clear wins; otherwise count enabled cycles until the value is all-ones.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// Watches a CPU run: waits for active to rise, counts cycles and data
// strobes while running, and reports a normal end (done) or an abnormal end
// (fail with a reason code). Results freeze once a terminal state is reached.
module mips_cpu_run_monitor
   import mips_tb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned START_DEADLINE = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                active,
   input  logic [31:0]         register_v0,
   input  logic [31:0]         instr_address,
   input  logic                data_read,
   input  logic                data_write,
   output logic                done,
   output logic                fail,
   output logic [1:0]          fail_code,
   output logic [31:0]         final_v0,
   output logic [CYCLE_W-1:0]  cycle_count,
   output logic [31:0]         last_pc,
   output logic [STROBE_W-1:0] read_count,
   output logic [STROBE_W-1:0] write_count,
   output logic                rw_conflict
);

   localparam logic [31:0] START_LIMIT  = 32'(START_DEADLINE);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] ONE          = 32'd1;

   run_state_t  state;
   logic [31:0] wait_cnt;
   logic        run_cycle;
   logic        timeout_hit;

   // A counted cycle is one spent in RUNNING with active still high; the
   // cycle in which active falls contributes nothing to the counters.
   assign run_cycle   = (state == RUNNING) && active;
   assign timeout_hit = run_cycle && (cycle_count == TIMEOUT_LAST);

   sat_counter #(.WIDTH(CYCLE_W)) u_cycle_cnt (
      .clk    (clk),
      .clear  (reset),
      .enable (run_cycle),
      .count  (cycle_count)
   );

   sat_counter #(.WIDTH(STROBE_W)) u_read_cnt (
      .clk    (clk),
      .clear  (reset),
      .enable (run_cycle && data_read),
      .count  (read_count)
   );

   sat_counter #(.WIDTH(STROBE_W)) u_write_cnt (
      .clk    (clk),
      .clear  (reset),
      .enable (run_cycle && data_write),
      .count  (write_count)
   );

   // Run FSM with registered result outputs; reset overrides every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_START;
         wait_cnt    <= '0;
         final_v0    <= '0;
         last_pc     <= '0;
         done        <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= FAIL_NONE;
         rw_conflict <= 1'b0;
      end else begin
         case (state)
            WAIT_START: begin
               if (active) begin
                  state <= RUNNING;
               end else if (wait_cnt == START_LIMIT) begin
                  state     <= FAIL;
                  fail      <= 1'b1;
                  fail_code <= FAIL_NOSTART;
               end else begin
                  wait_cnt <= wait_cnt + ONE;
               end
            end
            RUNNING: begin
               // active low ends the run normally even if the timeout
               // count was just about to be reached.
               if (!active) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  final_v0 <= register_v0;
               end else begin
                  last_pc <= instr_address;
                  if (data_read && data_write) begin
                     rw_conflict <= 1'b1;
                  end
                  if (timeout_hit) begin
                     state     <= FAIL;
                     fail      <= 1'b1;
                     fail_code <= FAIL_TIMEOUT;
                  end
               end
            end
            default: begin
               // DONE / FAIL: everything holds until reset.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Self-checking bench for mips_cpu_run_monitor: a run-level reference model
// compared every cycle, plus literal expectations for each directed scenario.
module tb_mips_cpu_run_monitor;

   localparam int unsigned TO = 50;
   localparam int unsigned SD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, active = 1'b0, data_read = 1'b0, data_write = 1'b0;
   logic [31:0] register_v0 = '0, instr_address = '0;
   logic        done, fail, rw_conflict;
   logic [1:0]  fail_code;
   logic [31:0] final_v0, cycle_count, last_pc;
   logic [15:0] read_count, write_count;

   mips_cpu_run_monitor #(.TIMEOUT_CYCLES(TO), .START_DEADLINE(SD)) dut (
      .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
      .instr_address(instr_address), .data_read(data_read), .data_write(data_write),
      .done(done), .fail(fail), .fail_code(fail_code), .final_v0(final_v0),
      .cycle_count(cycle_count), .last_pc(last_pc), .read_count(read_count),
      .write_count(write_count), .rw_conflict(rw_conflict)
   );

   // Second instance with a long timeout, used to reach strobe saturation.
   logic        s_reset = 1'b1, s_active = 1'b0, s_rd = 1'b0, s_wr = 1'b0;
   logic        s_done, s_fail, s_conf;
   logic [1:0]  s_code;
   logic [31:0] s_v0, s_cyc, s_pc;
   logic [15:0] s_rcnt, s_wcnt;

   mips_cpu_run_monitor #(.TIMEOUT_CYCLES(70000), .START_DEADLINE(2)) dut_s (
      .clk(clk), .reset(s_reset), .active(s_active), .register_v0(32'h0000_0077),
      .instr_address(32'h0000_1000), .data_read(s_rd), .data_write(s_wr),
      .done(s_done), .fail(s_fail), .fail_code(s_code), .final_v0(s_v0),
      .cycle_count(s_cyc), .last_pc(s_pc), .read_count(s_rcnt),
      .write_count(s_wcnt), .rw_conflict(s_conf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (run-level view) ----------------
   // phase: 0 waiting for start, 1 running, 2 finished
   int          m_phase = 0;
   longint      m_wait, m_cyc, m_rd, m_wr;
   bit          m_done, m_fail, m_conf, m_valid = 0;
   logic [1:0]  m_code;
   logic [31:0] m_v0, m_pc;

   function automatic longint lmin(input longint a, input longint b);
      return (a < b) ? a : b;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_phase = 0; m_wait = 0; m_cyc = 0; m_rd = 0; m_wr = 0;
         m_done = 0; m_fail = 0; m_conf = 0; m_code = 2'b00; m_v0 = '0; m_pc = '0;
         m_valid = 1;
      end else if (m_phase == 0) begin
         if (active) m_phase = 1;
         else if (m_wait >= longint'(SD)) begin
            m_fail = 1; m_code = 2'b01; m_phase = 2;
         end else m_wait++;
      end else if (m_phase == 1) begin
         if (!active) begin
            m_done = 1; m_v0 = register_v0; m_phase = 2;
         end else begin
            m_cyc = lmin(m_cyc + 1, 64'hFFFF_FFFF);
            m_pc  = instr_address;
            if (data_read)  m_rd = lmin(m_rd + 1, 65535);
            if (data_write) m_wr = lmin(m_wr + 1, 65535);
            if (data_read && data_write) m_conf = 1;
            if (m_cyc >= longint'(TO)) begin
               m_fail = 1; m_code = 2'b10; m_phase = 2;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         check("done",        32'(done),        32'(m_done));
         check("fail",        32'(fail),        32'(m_fail));
         check("fail_code",   32'(fail_code),   32'(m_code));
         check("final_v0",    final_v0,         m_v0);
         check("cycle_count", cycle_count,      32'(m_cyc));
         check("last_pc",     last_pc,          m_pc);
         check("read_count",  32'(read_count),  32'(m_rd));
         check("write_count", 32'(write_count), 32'(m_wr));
         check("rw_conflict", 32'(rw_conflict), 32'(m_conf));
         check("done_xor_fail", 32'(done & fail), 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic a, input logic rd, input logic wr,
                        input logic [31:0] pc, input logic [31:0] v0);
      active = a; data_read = rd; data_write = wr; instr_address = pc; register_v0 = v0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick(1);
      reset = 1'b0;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_done"},  32'(done),        32'd0);
      check({tag, "_fail"},  32'(fail),        32'd0);
      check({tag, "_code"},  32'(fail_code),   32'd0);
      check({tag, "_cyc"},   cycle_count,      32'd0);
      check({tag, "_rd"},    32'(read_count),  32'd0);
      check({tag, "_wr"},    32'(write_count), 32'd0);
      check({tag, "_pc"},    last_pc,          32'd0);
      check({tag, "_v0"},    final_v0,         32'd0);
      check({tag, "_conf"},  32'(rw_conflict), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Normal run: one idle cycle, 20 counted cycles, ends with v0=5.
      tick(1);
      do_reset();
      check_cleared("rst");
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0040_0000 + 32'(4 * i), 32'h0); tick(1);
      end
      drive(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0005); tick(1);
      check("run_done",   32'(done),   32'd1);
      check("run_fail",   32'(fail),   32'd0);
      check("run_v0",     final_v0,    32'd5);
      check("run_cyc",    cycle_count, 32'd20);
      check("run_lastpc", last_pc,     32'h0040_004C);
      check("run_rd",     32'(read_count), 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h9999); tick(3);
      check("run_hold_cyc", cycle_count, 32'd20);
      check("run_hold_v0",  final_v0,    32'd5);

      // No start: two idle cycles are tolerated, the third fails.
      do_reset();
      check_cleared("rst2");
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(2);
      check("nostart_edge_fail", 32'(fail), 32'd0);
      tick(1);
      check("nostart_fail", 32'(fail),      32'd1);
      check("nostart_code", 32'(fail_code), 32'd1);
      check("nostart_done", 32'(done),      32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); tick(2);
      check("nostart_hold_cyc", cycle_count, 32'd0);

      // Late start on the last allowed cycle still runs.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(2);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      tick(3);
      check("late_cyc",  cycle_count, 32'd3);
      check("late_fail", 32'(fail),   32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      check("late_done", 32'(done), 32'd1);

      // Timeout with active held high.
      do_reset();
      tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0); tick(1);
      tick(49);
      check("to_pre_fail", 32'(fail),   32'd0);
      check("to_pre_cyc",  cycle_count, 32'd49);
      tick(1);
      check("to_fail", 32'(fail),      32'd1);
      check("to_code", 32'(fail_code), 32'd2);
      check("to_cyc",  cycle_count,    32'd50);
      check("to_done", 32'(done),      32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(2);
      check("to_hold_done", 32'(done),   32'd0);
      check("to_hold_cyc",  cycle_count, 32'd50);

      // Strobe counting and read/write conflict.
      do_reset();
      tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, (i < 3), (i >= 3), 32'h100 + 32'(i), 32'h0); tick(1);
      end
      check("rw_pre_conf", 32'(rw_conflict), 32'd0);
      drive(1'b1, 1'b1, 1'b1, 32'h200, 32'h0); tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h204, 32'h0); tick(1);
      drive(1'b0, 1'b1, 1'b1, 32'h300, 32'hAB); tick(1);
      check("rw_rd",   32'(read_count),  32'd4);
      check("rw_wr",   32'(write_count), 32'd3);
      check("rw_conf", 32'(rw_conflict), 32'd1);
      check("rw_cyc",  cycle_count,      32'd7);
      check("rw_pc",   last_pc,          32'h204);

      // Reset in the middle of a run, then a fresh run.
      do_reset();
      tick(1);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0); tick(1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 1'b1, 32'h500 + 32'(i), 32'h0); tick(1);
      end
      reset = 1'b1; tick(1);
      check_cleared("midrst");
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0); tick(1);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h600 + 32'(i), 32'h0); tick(1);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1234); tick(1);
      check("rerun_done", 32'(done),       32'd1);
      check("rerun_cyc",  cycle_count,     32'd5);
      check("rerun_rd",   32'(read_count), 32'd5);
      check("rerun_v0",   final_v0,        32'h0000_1234);
      check("rerun_conf", 32'(rw_conflict), 32'd0);

      // active falls on the cycle that would have timed out: done wins.
      do_reset();
      tick(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0); tick(1);
      tick(49);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0042); tick(1);
      check("edge_done", 32'(done),      32'd1);
      check("edge_fail", 32'(fail),      32'd0);
      check("edge_code", 32'(fail_code), 32'd0);
      check("edge_cyc",  cycle_count,    32'd49);

      // Strobe counter saturation on the long-timeout instance.
      s_reset = 1'b1; tick(1);
      s_reset = 1'b0; s_active = 1'b1; s_rd = 1'b1; s_wr = 1'b1;
      tick(1);
      tick(65534);
      check("sat_rd_pre", 32'(s_rcnt), 32'h0000_FFFE);
      tick(1);
      check("sat_rd_max", 32'(s_rcnt), 32'h0000_FFFF);
      tick(5);
      check("sat_rd_hold", 32'(s_rcnt), 32'h0000_FFFF);
      check("sat_wr_hold", 32'(s_wcnt), 32'h0000_FFFF);
      check("sat_cyc",     s_cyc,       32'd65540);
      check("sat_fail",    32'(s_fail), 32'd0);
      s_active = 1'b0; tick(1);
      check("sat_done", 32'(s_done), 32'd1);
      check("sat_v0",   s_v0,        32'h0000_0077);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
